// File: rtl/sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl
// Brief    : SAR ADC conversion sequencer. It runs the sample phase, launches
//            the pulse_shreg strobe and resolves one bit per one-hot tap.
// Revision : 1.0 - initial release
// ============================================================================
module sar_ctrl #(
    parameter int N_BITS        = 10,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_arstn,
    input  logic              i_start,
    input  logic              i_cmp,
    input  logic [N_BITS-1:0] i_taps,
    output logic              o_pulse,
    output logic              o_sample,
    output logic [N_BITS-1:0] o_dac,
    output logic              o_busy,
    output logic [N_BITS-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ack,
    output logic              o_err
);

    localparam int KW  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [KW-1:0]  c_K_TOP   = KW'(N_BITS - 1);
    localparam logic [SCW-1:0] c_SC_LAST = SCW'(SAMPLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_LAUNCH  = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_BITS-1:0] r_sar;
    logic [N_BITS-1:0] r_data;
    logic [KW-1:0]     r_bit;
    logic [SCW-1:0]    r_scnt;
    logic              r_valid;
    logic              r_err;
    logic [N_BITS-1:0] w_exp_taps;
    logic              w_tap_ok;
    logic [N_BITS-1:0] w_sar_next;

    assign w_exp_taps = N_BITS'(1) << r_bit;
    assign w_tap_ok   = (i_taps == w_exp_taps);

    always_comb begin
        w_sar_next        = r_sar;
        w_sar_next[r_bit] = i_cmp;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_SAMPLE;
            S_SAMPLE:  if (r_scnt == c_SC_LAST) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_CONVERT;
            S_CONVERT: begin
                // Any tap pattern other than the expected one-hot aborts.
                if (!w_tap_ok)            w_next = S_IDLE;
                else if (r_bit == '0)     w_next = S_DONE;
            end
            S_DONE:    if (i_ack) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_sar   <= '0;
            r_data  <= '0;
            r_bit   <= '0;
            r_scnt  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_scnt  <= '0;
                        r_sar   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                S_SAMPLE: r_scnt <= r_scnt + SCW'(1);
                S_LAUNCH: r_bit  <= c_K_TOP;
                S_CONVERT: begin
                    if (w_tap_ok) begin
                        r_sar <= w_sar_next;
                        if (r_bit == '0) begin
                            r_data  <= w_sar_next;
                            r_valid <= 1'b1;
                        end else begin
                            r_bit <= r_bit - KW'(1);
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: if (i_ack) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_pulse  = (r_state == S_LAUNCH);
    assign o_sample = (r_state == S_SAMPLE);
    assign o_busy   = (r_state == S_SAMPLE) || (r_state == S_LAUNCH) || (r_state == S_CONVERT);
    assign o_dac    = r_sar | i_taps;
    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_ctrl
// Brief    : Self-checking bench for sar_ctrl with a pulse_shreg model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic         i_start = 1'b0;
    logic         i_ack = 1'b0;
    logic         i_cmp;
    logic [N-1:0] i_taps;
    logic         o_pulse, o_sample, o_busy, o_valid, o_err;
    logic [N-1:0] o_dac, o_data;

    logic [N-1:0] taps_q;
    logic         fault = 1'b0;
    logic [N-1:0] vin = '0;
    logic [N-1:0] rbits = '0;
    int           cmp_mode = 0;
    int           pulse_cnt = 0;
    int           err_cnt = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    typedef struct {
        logic [N-1:0] vin;
        int           mode;
        logic [N-1:0] exp;
        int           ack_dly;
    } vec_t;

    sar_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(2)) dut (
        .i_clk(clk), .i_arstn(arstn), .i_start(i_start), .i_cmp(i_cmp),
        .i_taps(i_taps), .o_pulse(o_pulse), .o_sample(o_sample), .o_dac(o_dac),
        .o_busy(o_busy), .o_data(o_data), .o_valid(o_valid), .i_ack(i_ack),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    // pulse_shreg model: the launch pulse walks MSB to LSB, one tap per cycle
    always @(posedge clk or negedge arstn) begin
        if (!arstn) taps_q <= '0;
        else        taps_q <= {o_pulse, taps_q[N-1:1]};
    end
    assign i_taps = fault ? '0 : taps_q;

    // mode 0: ideal comparator on vin, 1: tied high, 2: tied low, 3: bit-per-trial from rbits
    assign i_cmp = (cmp_mode == 0) ? (vin >= o_dac) :
                   (cmp_mode == 1) ? 1'b1 :
                   (cmp_mode == 2) ? 1'b0 : |(rbits & i_taps);

    always @(posedge clk) begin
        if (o_pulse) pulse_cnt <= pulse_cnt + 1;
        if (o_err)   err_cnt   <= err_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_ack(input int dly, input logic [N-1:0] exp, input string tag);
        repeat (dly) begin
            @(negedge clk);
            chk({tag, "_valid_held"}, 32'(o_valid), 32'd1);
        end
        @(negedge clk);
        i_ack = 1'b1;
        @(posedge clk);
        #1 i_ack = 1'b0;
        chk({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        chk({tag, "_data_hold"}, 32'(o_data), 32'(exp));
    endtask

    task automatic convert(input logic [N-1:0] v, input int mode, input logic [N-1:0] exp,
                           input int ack_dly, input bit spam, input string tag);
        logic [N-1:0] q[$];
        logic [N-1:0] e;
        int lat, p0, k;
        @(negedge clk);
        vin = v; cmp_mode = mode; i_start = 1'b1; p0 = pulse_cnt;
        @(posedge clk);
        #1 i_start = 1'b0;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            if (i_taps != '0) q.push_back(o_dac);
            else if (o_busy) chk({tag, "_dac_pre"}, 32'(o_dac), 32'd0);
            if (spam) begin
                i_start = 1'($urandom % 2);
                i_ack   = 1'($urandom % 2);
            end
            @(posedge clk);
            #1 lat++;
        end
        i_start = 1'b0; i_ack = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd13);
        chk({tag, "_data"}, 32'(o_data), 32'(exp));
        chk({tag, "_pulses"}, 32'(pulse_cnt - p0), 32'd1);
        chk({tag, "_ntrials"}, 32'(q.size()), 32'(N));
        // trial k presents the already-decided bits above k plus the bit under test
        for (int j = 0; j < q.size() && j < N; j++) begin
            k = N - 1 - j;
            e = N'(((int'(exp) >> (k + 1)) << (k + 1)) | (1 << k));
            chk({tag, "_trial"}, 32'(q[j]), 32'(e));
        end
        do_ack(ack_dly, exp, tag);
    endtask

    initial begin
        vec_t tbl[7];
        int   cyc, p0, n;
        logic [N-1:0] r;

        tbl[0] = '{vin: 10'h2A5, mode: 0, exp: 10'h2A5, ack_dly: 0};
        tbl[1] = '{vin: 10'h000, mode: 1, exp: 10'h3FF, ack_dly: 5};
        tbl[2] = '{vin: 10'h3FF, mode: 2, exp: 10'h000, ack_dly: 5};
        tbl[3] = '{vin: 10'h3FF, mode: 0, exp: 10'h3FF, ack_dly: 1};
        tbl[4] = '{vin: 10'h000, mode: 0, exp: 10'h000, ack_dly: 0};
        tbl[5] = '{vin: 10'h200, mode: 0, exp: 10'h200, ack_dly: 2};
        tbl[6] = '{vin: 10'h1FF, mode: 0, exp: 10'h1FF, ack_dly: 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse", 32'(o_pulse), 32'd0);
        chk("rst_sample", 32'(o_sample), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_dac", 32'(o_dac), 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            convert(tbl[i].vin, tbl[i].mode, tbl[i].exp, tbl[i].ack_dly, 1'b0, "vec");

        for (int i = 0; i < 10; i++) begin
            r = N'($urandom);
            rbits = N'($urandom);
            if (i % 2 == 0) convert(r, 0, r, int'($urandom_range(0, 3)), 1'b0, "rnd_ideal");
            else            convert(r, 3, rbits, int'($urandom_range(0, 3)), 1'b0, "rnd_bits");
        end

        // back-to-back: start held high throughout 40 cycles
        @(negedge clk);
        vin = 10'h155; cmp_mode = 0; i_start = 1'b1; p0 = pulse_cnt; cyc = 0;
        while (!o_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_first", 32'(o_data), 32'h155);
        vin = 10'h0AA;
        repeat (2) begin @(negedge clk); cyc++; end
        i_ack = 1'b1;
        @(negedge clk); cyc++;
        i_ack = 1'b0;
        chk("b2b_idle_busy", 32'(o_busy), 32'd0);
        chk("b2b_idle_valid", 32'(o_valid), 32'd0);
        while (!o_valid && cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_second", 32'(o_data), 32'h0AA);
        while (cyc < 40) begin @(negedge clk); cyc++; end
        chk("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
        chk("b2b_valid_held", 32'(o_valid), 32'd1);
        i_start = 1'b0;
        do_ack(0, 10'h0AA, "b2b");

        // tap fault in the 4th convert cycle
        convert(10'h155, 0, 10'h155, 0, 1'b0, "pre_fault");
        @(negedge clk);
        vin = 10'h3C3; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (i_taps == '0 && n < 20);
        repeat (3) @(negedge clk);
        fault = 1'b1;
        @(posedge clk);
        #1 fault = 1'b0;
        chk("fault_err", 32'(o_err), 32'd1);
        chk("fault_busy", 32'(o_busy), 32'd0);
        chk("fault_valid", 32'(o_valid), 32'd0);
        chk("fault_data", 32'(o_data), 32'h155);
        @(posedge clk);
        #1 chk("fault_err_once", 32'(o_err), 32'd0);
        repeat (12) @(negedge clk);
        chk("fault_err_total", 32'(err_cnt), 32'd1);
        chk("fault_valid_later", 32'(o_valid), 32'd0);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        vin = 10'h3FF; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst_pre_busy", 32'(o_busy), 32'd1);
        #2 arstn = 1'b0;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_pulse", 32'(o_pulse), 32'd0);
        chk("arst_sample", 32'(o_sample), 32'd0);
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_data", 32'(o_data), 32'd0);
        #29 arstn = 1'b1;
        repeat (12) @(negedge clk);
        chk("arst_no_err", 32'(err_cnt), 32'd1);
        convert(10'h001, 0, 10'h001, 0, 1'b0, "post_rst");

        // stray start/ack pulses while busy must not disturb the conversion
        convert(10'h2A5, 0, 10'h2A5, 2, 1'b1, "spam");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
